// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store.
// One transaction at a time: arbitrate in IDLE, hold the request in REQ, collect read data in WAIT.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    // load/store requester
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic              d_unsigned_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_misalign_o,
    // memory bus
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e            r_state;
    state_e            w_next_state;
    owner_e            r_last_owner;
    owner_e            r_owner;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_fetch_wins;
    logic              w_data_wins;
    logic              w_misalign;
    logic              w_launch;
    logic [3:0]        w_d_be;
    logic [31:0]       w_d_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_data;

    // Round robin: on a conflict the requester that did not launch last goes first.
    assign w_fetch_wins = if_req_i && (!d_req_i || r_last_owner == OWN_DATA);
    assign w_data_wins  = d_req_i && !w_fetch_wins;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_misalign = 1'b0;
        w_d_be     = 4'b1111;
        w_d_wdata  = d_wdata_i;
        case (d_size_i)
            SZ_BYTE: begin
                w_d_be    = 4'b0001 << d_addr_i[1:0];
                w_d_wdata = {4{d_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_misalign = d_addr_i[0];
                w_d_be     = 4'b0011 << d_addr_i[1:0];
                w_d_wdata  = {2{d_wdata_i[15:0]}};
            end
            SZ_WORD: w_misalign = |d_addr_i[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    // Load lane extraction uses the byte offset captured at launch.
    assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load_data = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        if_gnt_o     = 1'b0;
        if_rvalid_o  = 1'b0;
        if_rdata_o   = 32'h0;
        d_gnt_o      = 1'b0;
        d_rvalid_o   = 1'b0;
        d_rdata_o    = 32'h0;
        d_misalign_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_data_wins && w_misalign) begin
                    d_gnt_o      = 1'b1;
                    d_misalign_o = 1'b1;
                end else if (w_fetch_wins || w_data_wins) begin
                    w_launch     = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    if (r_owner == OWN_FETCH) begin
                        if_gnt_o = 1'b1;
                    end else begin
                        d_gnt_o = 1'b1;
                    end
                    w_next_state = r_we ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (r_owner == OWN_FETCH) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end else begin
                        d_rvalid_o = 1'b1;
                        d_rdata_o  = w_load_data;
                    end
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWN_DATA;
        end else begin
            r_state <= w_next_state;
            if (w_launch) begin
                r_last_owner <= w_fetch_wins ? OWN_FETCH : OWN_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_FETCH;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SZ_WORD;
            r_be       <= 4'b0000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
        end else if (w_launch) begin
            r_owner    <= w_fetch_wins ? OWN_FETCH : OWN_DATA;
            r_we       <= w_fetch_wins ? 1'b0 : d_we_i;
            r_unsigned <= w_fetch_wins ? 1'b0 : d_unsigned_i;
            r_size     <= w_fetch_wins ? SZ_WORD : d_size_i;
            r_be       <= w_fetch_wins ? 4'b1111 : w_d_be;
            r_addr     <= w_fetch_wins ? if_addr_i : d_addr_i;
            r_wdata    <= w_fetch_wins ? 32'h0 : w_d_wdata;
        end
    end

    assign mem_req_o   = (r_state == ST_REQ);
    assign mem_we_o    = (r_state == ST_REQ) && r_we;
    assign mem_be_o    = r_be;
    assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder, a scoreboard of expected
// grant/response events, and a monitor that pops and compares each event as it appears.
module tb_mem_port_arbiter;

    localparam logic [1:0] K_GF = 2'd0;
    localparam logic [1:0] K_GD = 2'd1;
    localparam logic [1:0] K_RF = 2'd2;
    localparam logic [1:0] K_RD = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        mis;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [1:0]  d_size_i;
    logic        d_unsigned_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];
    logic [31:0] mem_model [logic [31:0]];
    int stall_cycles;
    int rd_delay;
    int stall_cnt;
    int rd_cnt;
    logic [31:0] rd_addr;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_size_i     (d_size_i),
        .d_unsigned_i (d_unsigned_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .d_misalign_o (d_misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_gnt(input logic [1:0] kind, input logic [31:0] addr,
                                     input logic [3:0] be, input logic we,
                                     input logic [31:0] wdata, input logic mis);
        exp_t e;
        e       = '0;
        e.kind  = kind;
        e.addr  = addr;
        e.be    = be;
        e.we    = we;
        e.wdata = wdata;
        e.mis   = mis;
        sb.push_back(e);
    endfunction

    function automatic void push_rv(input logic [1:0] kind, input logic [31:0] rdata);
        exp_t e;
        e       = '0;
        e.kind  = kind;
        e.rdata = rdata;
        sb.push_back(e);
    endfunction

    // Memory responder: accepts after stall_cycles, returns read data rd_delay cycles later.
    // A pending read is not cancelled by reset, which produces a stale response.
    initial begin
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        stall_cnt    = 0;
        rd_cnt       = 0;
        rd_addr      = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 32'h0;
                end
            end else if (rst_n && mem_req_o) begin
                if (stall_cnt < stall_cycles) begin
                    stall_cnt++;
                end else begin
                    stall_cnt   = 0;
                    mem_ready_i = 1'b1;
                    if (!mem_we_o) begin
                        rd_cnt  = rd_delay;
                        rd_addr = mem_addr_o;
                    end
                end
            end
        end
    end

    task automatic handle(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_unexpected: observed event kind %0d expected none", kind);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("evt_kind", {30'h0, kind}, {30'h0, e.kind});
            if (kind == K_GF || kind == K_GD) begin
                check("gnt_mem_req", mem_req_o, !e.mis);
                if (kind == K_GD) check("gnt_misalign", d_misalign_o, e.mis);
                if (!e.mis) begin
                    check("gnt_mem_addr", mem_addr_o, e.addr);
                    check("gnt_mem_be", mem_be_o, e.be);
                    check("gnt_mem_we", mem_we_o, e.we);
                    if (e.we) check("gnt_mem_wdata", mem_wdata_o, e.wdata);
                end
            end else begin
                check("rdata", data, e.rdata);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (if_gnt_o)    handle(K_GF, 32'h0);
                if (d_gnt_o)     handle(K_GD, 32'h0);
                if (if_rvalid_o) handle(K_RF, if_rdata_o);
                if (d_rvalid_o)  handle(K_RD, d_rdata_o);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_if_gnt"}, if_gnt_o, 0);
        check({tag, "_if_rvalid"}, if_rvalid_o, 0);
        check({tag, "_if_rdata"}, if_rdata_o, 0);
        check({tag, "_d_gnt"}, d_gnt_o, 0);
        check({tag, "_d_rvalid"}, d_rvalid_o, 0);
        check({tag, "_d_rdata"}, d_rdata_o, 0);
        check({tag, "_d_misalign"}, d_misalign_o, 0);
        check({tag, "_mem_req"}, mem_req_o, 0);
        check({tag, "_mem_we"}, mem_we_o, 0);
        check({tag, "_mem_be"}, mem_be_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3 check_outputs_zero("pulse_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one data access, hold it until granted, then wait for read data if expected.
    task automatic data_op(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_rv);
        logic got;
        got = 1'b0;
        @(negedge clk);
        d_we_i       = we;
        d_size_i     = size;
        d_unsigned_i = uns;
        d_addr_i     = addr;
        d_wdata_i    = wdata;
        d_req_i      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (d_gnt_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_gnt_seen"}, got, 1);
        @(negedge clk);
        d_req_i = 1'b0;
        if (exp_rv) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                #3;
                if (d_rvalid_o) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check({tag, "_rvalid_seen"}, got, 1);
        end else begin
            #3;
            check({tag, "_no_rvalid"}, d_rvalid_o, 0);
            check({tag, "_no_mem_req"}, mem_req_o, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        int         ng;
        logic [3:0] seq;
        rst_n        = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = 32'h0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_size_i     = 2'b00;
        d_unsigned_i = 1'b0;
        d_addr_i     = 32'h0;
        d_wdata_i    = 32'h0;
        stall_cycles = 0;
        rd_delay     = 1;
        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h200] = 32'h80112233;
        mem_model[32'h300] = 32'h00000013;
        mem_model[32'h400] = 32'hCAFEF00D;

        @(negedge clk);
        #3 check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch alone: grant one cycle after sampling, data one cycle later.
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        push_gnt(K_GF, 32'h100, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_rv(K_RF, 32'hDEADBEEF);
        #3 check("f_idle_no_gnt", if_gnt_o, 0);
        @(negedge clk);
        #3;
        check("f_mem_req", mem_req_o, 1);
        check("f_mem_addr", mem_addr_o, 32'h100);
        check("f_mem_be", mem_be_o, 4'b1111);
        check("f_gnt_k1", if_gnt_o, 1);
        @(negedge clk);
        if_req_i = 1'b0;
        #3;
        check("f_rvalid_k2", if_rvalid_o, 1);
        check("f_rdata", if_rdata_o, 32'hDEADBEEF);
        @(negedge clk);
        #3 check("f_back_idle", mem_req_o, 0);

        // Conflict from reset: fetch first, then strict alternation.
        pulse_reset();
        @(negedge clk);
        if_addr_i = 32'h300;
        d_we_i    = 1'b0;
        d_size_i  = 2'b10;
        d_addr_i  = 32'h400;
        for (int r = 0; r < 2; r++) begin
            push_gnt(K_GF, 32'h300, 4'b1111, 1'b0, 32'h0, 1'b0);
            push_rv(K_RF, 32'h00000013);
            push_gnt(K_GD, 32'h400, 4'b1111, 1'b0, 32'h0, 1'b0);
            push_rv(K_RD, 32'hCAFEF00D);
        end
        if_req_i = 1'b1;
        d_req_i  = 1'b1;
        ng  = 0;
        seq = 4'b0000;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            #3;
            if (if_gnt_o || d_gnt_o) begin
                seq = {seq[2:0], d_gnt_o};
                ng++;
            end
            if (ng < 4) @(negedge clk);
        end
        check("arb_grant_count", ng, 4);
        check("arb_order_FDFD", seq, 4'b0101);
        @(negedge clk);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        repeat (3) @(negedge clk);

        // Loads with lane extraction and extension.
        push_gnt(K_GD, 32'h200, 4'b1000, 1'b0, 32'h0, 1'b0);
        push_rv(K_RD, 32'hFFFFFF80);
        data_op("lb", 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1'b1);
        push_gnt(K_GD, 32'h200, 4'b1000, 1'b0, 32'h0, 1'b0);
        push_rv(K_RD, 32'h00000080);
        data_op("lbu", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b1);
        push_gnt(K_GD, 32'h200, 4'b1100, 1'b0, 32'h0, 1'b0);
        push_rv(K_RD, 32'hFFFF8011);
        data_op("lh", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b1);

        // Stores with replicated write data.
        push_gnt(K_GD, 32'h100, 4'b0010, 1'b1, 32'hABABABAB, 1'b0);
        data_op("sb", 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 1'b0);
        push_gnt(K_GD, 32'h100, 4'b1100, 1'b1, 32'h12341234, 1'b0);
        data_op("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 1'b0);

        // Trapped accesses: grant and misalign in the request cycle, no memory access.
        push_gnt(K_GD, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1);
        data_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0);
        push_gnt(K_GD, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1);
        data_op("sz11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0);

        // Stall five cycles, then reset while waiting for read data.
        stall_cycles = 5;
        rd_delay     = 3;
        push_gnt(K_GD, 32'h200, 4'b1111, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        d_we_i       = 1'b0;
        d_size_i     = 2'b10;
        d_unsigned_i = 1'b0;
        d_addr_i     = 32'h200;
        d_req_i      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("stall_mem_req", mem_req_o, 1);
            check("stall_mem_addr", mem_addr_o, 32'h200);
            check("stall_mem_be", mem_be_o, 4'b1111);
            check("stall_no_gnt", d_gnt_o, 0);
        end
        @(negedge clk);
        #3 check("stall_gnt", d_gnt_o, 1);
        @(negedge clk);
        d_req_i = 1'b0;
        rst_n   = 1'b0;
        #3 check_outputs_zero("wait_rst");
        @(negedge clk);
        rst_n        = 1'b1;
        stall_cycles = 0;
        @(negedge clk);
        #3;
        check("stale_d_rvalid", d_rvalid_o, 0);
        check("stale_if_rvalid", if_rvalid_o, 0);
        check("stale_d_rdata", d_rdata_o, 0);
        rd_delay = 1;
        @(negedge clk);

        // Recovery after the aborted transaction.
        push_gnt(K_GD, 32'h400, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_rv(K_RD, 32'hCAFEF00D);
        data_op("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1);

        repeat (2) @(negedge clk);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_leftover: observed %0d pending events expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
